// File: rtl/hpdmc_cmdsched.sv
// Bank-aware SDRAM command scheduler: ACT/RD/WR/PRE/REF sequencing with
// per-bank open-row tracking and periodic auto-refresh.
module hpdmc_cmdsched #(
    parameter int ROW_BITS = 13,
    parameter int COL_BITS = 10
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic                         cmd_stb,
    input  logic                         cmd_we,
    input  logic [ROW_BITS+2+COL_BITS-1:0] cmd_addr,
    output logic                         cmd_ack,
    input  logic                         read_safe,
    input  logic                         write_safe,
    input  logic [3:0]                   precharge_safe,
    output logic                         read,
    output logic                         write,
    output logic [3:0]                   concerned_bank,
    input  logic [2:0]                   tim_rp,
    input  logic [2:0]                   tim_rcd,
    input  logic [3:0]                   tim_rfc,
    input  logic [10:0]                  tim_refi,
    output logic                         sdram_cs_n,
    output logic                         sdram_ras_n,
    output logic                         sdram_cas_n,
    output logic                         sdram_we_n,
    output logic [1:0]                   sdram_ba,
    output logic [ROW_BITS-1:0]          sdram_adr
);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_TRP, S_ACT, S_TRCD,
        S_ISSUE, S_PREALL, S_TRPALL, S_REF, S_TRFC
    } state_t;

    localparam logic [2:0] C_NOP = 3'b111;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;

    state_t                state_q, state_d;
    logic [3:0]            wait_q, wait_d;
    logic [3:0]            open_q, open_d;
    logic [ROW_BITS-1:0]   rows_q [4];
    logic [ROW_BITS-1:0]   rows_d [4];
    logic [10:0]           refcnt_q, refcnt_d;
    logic                  pend_q, pend_d;
    logic [2:0]            cmd_q, cmd_d;
    logic [1:0]            ba_q, ba_d;
    logic [ROW_BITS-1:0]   adr_q, adr_d;
    logic                  ack_q, ack_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic [3:0]            cb_q, cb_d;

    logic [ROW_BITS-1:0]   row;
    logic [1:0]            bank;
    logic [COL_BITS-1:0]   col;
    logic [3:0]            rp_n, rcd_n, rfc_n;

    assign row  = cmd_addr[ROW_BITS+2+COL_BITS-1 -: ROW_BITS];
    assign bank = cmd_addr[COL_BITS +: 2];
    assign col  = cmd_addr[COL_BITS-1:0];

    // A zero timing value still yields one NOP cycle.
    assign rp_n  = (tim_rp == 3'd0) ? 4'd1 : {1'b0, tim_rp};
    assign rcd_n = (tim_rcd == 3'd0) ? 4'd1 : {1'b0, tim_rcd};
    assign rfc_n = (tim_rfc == 4'd0) ? 4'd1 : tim_rfc;

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        open_d   = open_q;
        rows_d   = rows_q;
        pend_d   = pend_q;
        refcnt_d = refcnt_q;
        cmd_d    = C_NOP;
        ba_d     = '0;
        adr_d    = '0;
        ack_d    = 1'b0;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        cb_d     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    state_d = S_PREALL;
                end else if (cmd_stb && !ack_q) begin
                    if (!open_q[bank])
                        state_d = S_ACT;
                    else if (rows_q[bank] == row)
                        state_d = S_ISSUE;
                    else
                        state_d = S_PRE;
                end
            end
            S_PRE: begin
                if (precharge_safe[bank]) begin
                    cmd_d        = C_PRE;
                    ba_d         = bank;
                    open_d[bank] = 1'b0;
                    wait_d       = rp_n;
                    state_d      = S_TRP;
                end
            end
            S_TRP: begin
                if (wait_q == 4'd1) state_d = S_ACT;
                else wait_d = wait_q - 4'd1;
            end
            S_ACT: begin
                cmd_d        = C_ACT;
                ba_d         = bank;
                adr_d        = row;
                open_d[bank] = 1'b1;
                rows_d[bank] = row;
                wait_d       = rcd_n;
                state_d      = S_TRCD;
            end
            S_TRCD: begin
                if (wait_q == 4'd1) state_d = S_ISSUE;
                else wait_d = wait_q - 4'd1;
            end
            S_ISSUE: begin
                if (cmd_we ? write_safe : read_safe) begin
                    cmd_d                = cmd_we ? C_WR : C_RD;
                    ba_d                 = bank;
                    adr_d[COL_BITS-1:0]  = col;
                    ack_d                = 1'b1;
                    rd_d                 = !cmd_we;
                    wr_d                 = cmd_we;
                    cb_d[bank]           = 1'b1;
                    state_d              = S_IDLE;
                end
            end
            S_PREALL: begin
                if (&precharge_safe) begin
                    cmd_d     = C_PRE;
                    adr_d[10] = 1'b1;
                    open_d    = '0;
                    wait_d    = rp_n;
                    state_d   = S_TRPALL;
                end
            end
            S_TRPALL: begin
                if (wait_q == 4'd1) state_d = S_REF;
                else wait_d = wait_q - 4'd1;
            end
            S_REF: begin
                // The IDLE cycle that follows supplies the last tRFC NOP.
                cmd_d  = C_REF;
                pend_d = 1'b0;
                if (rfc_n == 4'd1) begin
                    state_d = S_IDLE;
                end else begin
                    wait_d  = rfc_n - 4'd1;
                    state_d = S_TRFC;
                end
            end
            S_TRFC: begin
                if (wait_q == 4'd1) state_d = S_IDLE;
                else wait_d = wait_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
        if (refcnt_q == 11'd0) begin
            refcnt_d = tim_refi;
            pend_d   = 1'b1;
        end else begin
            refcnt_d = refcnt_q - 11'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= S_IDLE;
            wait_q   <= '0;
            open_q   <= '0;
            rows_q   <= '{default: '0};
            refcnt_q <= tim_refi;
            pend_q   <= 1'b0;
            cmd_q    <= C_NOP;
            ba_q     <= '0;
            adr_q    <= '0;
            ack_q    <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            cb_q     <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            open_q   <= open_d;
            rows_q   <= rows_d;
            refcnt_q <= refcnt_d;
            pend_q   <= pend_d;
            cmd_q    <= cmd_d;
            ba_q     <= ba_d;
            adr_q    <= adr_d;
            ack_q    <= ack_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            cb_q     <= cb_d;
        end
    end

    assign sdram_cs_n     = 1'b0;
    assign sdram_ras_n    = cmd_q[2];
    assign sdram_cas_n    = cmd_q[1];
    assign sdram_we_n     = cmd_q[0];
    assign sdram_ba       = ba_q;
    assign sdram_adr      = adr_q;
    assign cmd_ack        = ack_q;
    assign read           = rd_q;
    assign write          = wr_q;
    assign concerned_bank = cb_q;

endmodule

// File: tb/tb_hpdmc_cmdsched.sv
// Directed bench for hpdmc_cmdsched: command order, gaps, refresh and
// reset abort observed on the SDRAM pins.
module tb_hpdmc_cmdsched;

    localparam logic [2:0] ACT = 3'b011;
    localparam logic [2:0] RD  = 3'b101;
    localparam logic [2:0] WR  = 3'b100;
    localparam logic [2:0] PRE = 3'b010;
    localparam logic [2:0] REF = 3'b001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, we;
    logic [24:0] addr;
    logic        ack;
    logic        rs, ws;
    logic [3:0]  ps;
    logic        rd_o, wr_o;
    logic [3:0]  cb;
    logic [2:0]  rp, rcd;
    logic [3:0]  rfc;
    logic [10:0] refi;
    logic        cs_n, ras_n, cas_n, we_n;
    logic [1:0]  ba;
    logic [12:0] adr;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [1:0]  s_ba;
    logic [12:0] s_adr;
    logic        s_ack, s_rd, s_wr;
    logic [3:0]  s_cb;
    int          s_cyc;

    hpdmc_cmdsched dut (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .cmd_stb(stb), .cmd_we(we), .cmd_addr(addr), .cmd_ack(ack),
        .read_safe(rs), .write_safe(ws), .precharge_safe(ps),
        .read(rd_o), .write(wr_o), .concerned_bank(cb),
        .tim_rp(rp), .tim_rcd(rcd), .tim_rfc(rfc), .tim_refi(refi),
        .sdram_cs_n(cs_n), .sdram_ras_n(ras_n), .sdram_cas_n(cas_n),
        .sdram_we_n(we_n), .sdram_ba(ba), .sdram_adr(adr)
    );

    always #5 clk = ~clk;
    always @(negedge clk) cyc <= cyc + 1;

    function automatic logic [24:0] mk(input int r, input int b, input int c);
        mk = {r[12:0], b[1:0], c[9:0]};
    endfunction

    // Samples pins on falling edges until a non-NOP command; 000 = timeout.
    task automatic next_cmd(input int limit, output logic [2:0] c, output int nops);
        nops = 0;
        c = 3'b000;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ({ras_n, cas_n, we_n} != 3'b111) begin
                c = {ras_n, cas_n, we_n};
                s_ba = ba; s_adr = adr; s_ack = ack;
                s_rd = rd_o; s_wr = wr_o; s_cb = cb; s_cyc = cyc;
                return;
            end
            nops++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cs_n, ras_n, cas_n, we_n} !== 4'b0111 || ba !== 2'd0 || adr !== 13'd0
            || ack !== 1'b0 || rd_o !== 1'b0 || wr_o !== 1'b0 || cb !== 4'd0) begin
            errors++;
            $display("FAIL reset: pins=%b ba=%0d adr=%0d ack=%b rd=%b wr=%b cb=%b want 0111/0/0/0/0/0/0000",
                     {cs_n, ras_n, cas_n, we_n}, ba, adr, ack, rd_o, wr_o, cb);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_act_read();
        logic [2:0] c; int n;
        stb = 1'b1; we = 1'b0; addr = mk(5, 0, 3);
        next_cmd(40, c, n);
        checks++;
        if (c !== ACT || s_ba !== 2'd0 || s_adr !== 13'd5) begin
            errors++;
            $display("FAIL act1: cmd=%b ba=%0d adr=%0d want 011/0/5", c, s_ba, s_adr);
        end
        next_cmd(40, c, n);
        checks++;
        if (c !== RD || s_ba !== 2'd0 || s_adr !== 13'd3 || n != 2) begin
            errors++;
            $display("FAIL rd1: cmd=%b ba=%0d adr=%0d nops=%0d want 101/0/3/2", c, s_ba, s_adr, n);
        end
        checks++;
        if (s_ack !== 1'b1 || s_rd !== 1'b1 || s_wr !== 1'b0 || s_cb !== 4'b0001) begin
            errors++;
            $display("FAIL rd1_flags: ack=%b rd=%b wr=%b cb=%b want 1/1/0/0001", s_ack, s_rd, s_wr, s_cb);
        end
        stb = 1'b0;
    endtask

    task automatic test_hit();
        logic [2:0] c; int n;
        @(negedge clk);
        stb = 1'b1; addr = mk(5, 0, 7);
        next_cmd(40, c, n);
        checks++;
        if (c !== RD || s_adr !== 13'd7 || s_ack !== 1'b1) begin
            errors++;
            $display("FAIL hit: cmd=%b adr=%0d ack=%b want 101/7/1", c, s_adr, s_ack);
        end
        stb = 1'b0;
    endtask

    task automatic test_miss_write();
        logic [2:0] c; int n;
        @(negedge clk);
        stb = 1'b1; we = 1'b1; addr = mk(9, 0, 12); ps = 4'b1110; ws = 1'b0;
        fork
            begin repeat (4) @(negedge clk); ps = 4'hF; end
            next_cmd(60, c, n);
        join
        checks++;
        if (c !== PRE || s_ba !== 2'd0 || s_adr[10] !== 1'b0 || n != 4) begin
            errors++;
            $display("FAIL pre_hold: cmd=%b ba=%0d a10=%b nops=%0d want 010/0/0/4", c, s_ba, s_adr[10], n);
        end
        next_cmd(40, c, n);
        checks++;
        if (c !== ACT || s_ba !== 2'd0 || s_adr !== 13'd9 || n != 3) begin
            errors++;
            $display("FAIL act_miss: cmd=%b ba=%0d adr=%0d nops=%0d want 011/0/9/3", c, s_ba, s_adr, n);
        end
        fork
            begin repeat (6) @(negedge clk); ws = 1'b1; end
            next_cmd(60, c, n);
        join
        checks++;
        if (c !== WR || s_adr !== 13'd12 || n != 6 || s_ack !== 1'b1
            || s_wr !== 1'b1 || s_rd !== 1'b0 || s_cb !== 4'b0001) begin
            errors++;
            $display("FAIL wr_hold: cmd=%b adr=%0d nops=%0d ack=%b wr=%b rd=%b cb=%b want 100/12/6/1/1/0/0001",
                     c, s_adr, n, s_ack, s_wr, s_rd, s_cb);
        end
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic test_refresh();
        logic [2:0] c; int n; int t1;
        refi = 11'd100;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        next_cmd(300, c, n);
        checks++;
        if (c !== PRE || s_adr[10] !== 1'b1) begin
            errors++;
            $display("FAIL preall1: cmd=%b a10=%b want 010/1", c, s_adr[10]);
        end
        next_cmd(40, c, n);
        t1 = s_cyc;
        checks++;
        if (c !== REF || n != 3) begin
            errors++;
            $display("FAIL ref1: cmd=%b nops=%0d want 001/3", c, n);
        end
        next_cmd(300, c, n);
        checks++;
        if (c !== PRE || s_adr[10] !== 1'b1) begin
            errors++;
            $display("FAIL preall2: cmd=%b a10=%b want 010/1", c, s_adr[10]);
        end
        next_cmd(40, c, n);
        checks++;
        if (c !== REF || s_cyc - t1 != 101) begin
            errors++;
            $display("FAIL ref_period: cmd=%b period=%0d want 001/101", c, s_cyc - t1);
        end
    endtask

    task automatic test_refresh_mid_miss();
        logic [2:0] c; int n;
        stb = 1'b1; we = 1'b0; addr = mk(2, 1, 4);
        next_cmd(40, c, n);
        next_cmd(40, c, n);
        checks++;
        if (c !== RD || s_ack !== 1'b1) begin
            errors++;
            $display("FAIL mm_open: cmd=%b ack=%b want 101/1", c, s_ack);
        end
        stb = 1'b0;
        @(negedge clk);
        stb = 1'b1; addr = mk(8, 1, 5); ps = 4'b1101;
        fork
            begin repeat (120) @(negedge clk); ps = 4'hF; end
            next_cmd(300, c, n);
        join
        checks++;
        if (c !== PRE || s_ba !== 2'd1 || s_adr[10] !== 1'b0 || n != 120) begin
            errors++;
            $display("FAIL mm_pre: cmd=%b ba=%0d a10=%b nops=%0d want 010/1/0/120", c, s_ba, s_adr[10], n);
        end
        next_cmd(40, c, n);
        checks++;
        if (c !== ACT || s_ba !== 2'd1 || s_adr !== 13'd8 || n != 3) begin
            errors++;
            $display("FAIL mm_act: cmd=%b ba=%0d adr=%0d nops=%0d want 011/1/8/3", c, s_ba, s_adr, n);
        end
        next_cmd(40, c, n);
        checks++;
        if (c !== RD || s_adr !== 13'd5 || s_ack !== 1'b1 || n != 2) begin
            errors++;
            $display("FAIL mm_rd: cmd=%b adr=%0d ack=%b nops=%0d want 101/5/1/2", c, s_adr, s_ack, n);
        end
        stb = 1'b0;
        @(negedge clk);
        stb = 1'b1; addr = mk(8, 1, 6);
        next_cmd(40, c, n);
        checks++;
        if (c !== PRE || s_adr[10] !== 1'b1) begin
            errors++;
            $display("FAIL mm_preall: cmd=%b a10=%b want 010/1", c, s_adr[10]);
        end
        next_cmd(40, c, n);
        checks++;
        if (c !== REF || n != 3) begin
            errors++;
            $display("FAIL mm_ref: cmd=%b nops=%0d want 001/3", c, n);
        end
        next_cmd(40, c, n);
        checks++;
        if (c !== ACT || s_ba !== 2'd1 || s_adr !== 13'd8 || n != 5) begin
            errors++;
            $display("FAIL mm_after_rfc: cmd=%b ba=%0d adr=%0d nops=%0d want 011/1/8/5", c, s_ba, s_adr, n);
        end
        next_cmd(40, c, n);
        checks++;
        if (c !== RD || s_adr !== 13'd6 || s_ack !== 1'b1) begin
            errors++;
            $display("FAIL mm_rd2: cmd=%b adr=%0d ack=%b want 101/6/1", c, s_adr, s_ack);
        end
        stb = 1'b0;
    endtask

    task automatic test_reset_trcd();
        logic [2:0] c; int n;
        refi = 11'd2047;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stb = 1'b1; addr = mk(7, 2, 1);
        next_cmd(40, c, n);
        next_cmd(40, c, n);
        stb = 1'b0;
        @(negedge clk);
        stb = 1'b1; addr = mk(4, 3, 0);
        next_cmd(40, c, n);
        checks++;
        if (c !== ACT || s_ba !== 2'd3) begin
            errors++;
            $display("FAIL trcd_act: cmd=%b ba=%0d want 011/3", c, s_ba);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({cs_n, ras_n, cas_n, we_n} !== 4'b0111 || ack !== 1'b0 || cb !== 4'd0) begin
            errors++;
            $display("FAIL async_rst: pins=%b ack=%b cb=%b want 0111/0/0000", {cs_n, ras_n, cas_n, we_n}, ack, cb);
        end
        stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; rcd = 3'd0;
        @(negedge clk);
        stb = 1'b1; addr = mk(7, 2, 9);
        next_cmd(40, c, n);
        checks++;
        if (c !== ACT || s_ba !== 2'd2 || s_adr !== 13'd7) begin
            errors++;
            $display("FAIL reopen: cmd=%b ba=%0d adr=%0d want 011/2/7", c, s_ba, s_adr);
        end
        next_cmd(40, c, n);
        checks++;
        if (c !== RD || s_adr !== 13'd9 || n != 1) begin
            errors++;
            $display("FAIL rcd0: cmd=%b adr=%0d nops=%0d want 101/9/1", c, s_adr, n);
        end
        stb = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; stb = 1'b0; we = 1'b0; addr = '0;
        rs = 1'b1; ws = 1'b1; ps = 4'hF;
        rp = 3'd3; rcd = 3'd2; rfc = 4'd5; refi = 11'd2047;
        test_reset();
        test_act_read();
        test_hit();
        test_miss_write();
        test_refresh();
        test_refresh_mid_miss();
        test_reset_trcd();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
